// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared core-stage codes, LSU state encoding and register-input mux codes
package gpu_pkg;

  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_e;

  localparam logic [1:0] RIM_ARITHMETIC = 2'b00;
  localparam logic [1:0] RIM_MEMORY     = 2'b01;
  localparam logic [1:0] RIM_CONSTANT   = 2'b10;
  localparam logic [1:0] RIM_MOVC       = 2'b11;

endpackage

// File: rtl/lsu_timeout_counter.sv
// rtl/lsu_timeout_counter.sv - counts ready-less WAITING edges and flags the aborting edge
module lsu_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Expires on the edge that would make the count reach TIMEOUT_CYCLES.
  assign expire_o = count_en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/thread_lsu.sv
// rtl/thread_lsu.sv - per-thread load/store unit running one valid/ready memory transaction per LDR/STR
module thread_lsu
  import gpu_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  output logic                 mem_read_valid,
  output logic [DATA_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [DATA_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);

  lsu_state_e           state_q, state_d;
  logic                 op_read_q, op_read_d;
  logic                 rvalid_q, rvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic [DATA_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 err_q, err_d;

  logic active_ready;
  logic expire;

  // Only the channel of the latched operation can complete the transaction.
  assign active_ready = op_read_q ? mem_read_ready : mem_write_ready;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      lsu_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
      ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (enable && (state_q != LSU_WAITING)),
        .count_en_i(enable && (state_q == LSU_WAITING) && !active_ready),
        .expire_o  (expire)
      );
    end else begin : g_no_timeout
      assign expire = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    op_read_d = op_read_q;
    rvalid_d  = rvalid_q;
    wvalid_d  = wvalid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    out_d     = out_q;
    err_d     = err_q;
    if (enable) begin
      case (state_q)
        LSU_IDLE: begin
          if ((core_state == CORE_REQUEST) &&
              (decoded_mem_read_enable || decoded_mem_write_enable)) begin
            state_d   = LSU_REQUESTING;
            op_read_d = decoded_mem_read_enable;
            err_d     = 1'b0;
          end
        end
        LSU_REQUESTING: begin
          state_d = LSU_WAITING;
          addr_d  = rs;
          if (op_read_q) begin
            rvalid_d = 1'b1;
          end else begin
            wvalid_d = 1'b1;
            wdata_d  = rt;
          end
        end
        LSU_WAITING: begin
          if (active_ready) begin
            state_d  = LSU_DONE;
            rvalid_d = 1'b0;
            wvalid_d = 1'b0;
            if (op_read_q) begin
              out_d = mem_read_data;
            end
          end else if (expire) begin
            state_d  = LSU_DONE;
            rvalid_d = 1'b0;
            wvalid_d = 1'b0;
            err_d    = 1'b1;
            out_d    = '0;
          end
        end
        LSU_DONE: begin
          if (core_state == CORE_UPDATE) begin
            state_d = LSU_IDLE;
          end
        end
        default: state_d = LSU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LSU_IDLE;
      op_read_q <= 1'b0;
      rvalid_q  <= 1'b0;
      wvalid_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      out_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_read_q <= op_read_d;
      rvalid_q  <= rvalid_d;
      wvalid_q  <= wvalid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      out_q     <= out_d;
      err_q     <= err_d;
    end
  end

  assign mem_read_valid    = rvalid_q;
  assign mem_read_address  = addr_q;
  assign mem_write_valid   = wvalid_q;
  assign mem_write_address = addr_q;
  assign mem_write_data    = wdata_q;
  assign lsu_state         = state_q;
  assign lsu_out           = out_q;
  assign lsu_error         = err_q;

endmodule

// File: tb/tb_thread_lsu.sv
// tb/tb_thread_lsu.sv - directed self-checking bench for thread_lsu (TIMEOUT_CYCLES=4)
module tb_thread_lsu;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] core_state;
  logic       rd_en, wr_en;
  logic [7:0] rs, rt;
  logic       mem_read_valid, mem_write_valid;
  logic [7:0] mem_read_address, mem_write_address, mem_write_data;
  logic       mem_read_ready, mem_write_ready;
  logic [7:0] mem_read_data;
  logic [1:0] lsu_state;
  logic [7:0] lsu_out;
  logic       lsu_error;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  thread_lsu #(.DATA_BITS(8), .TIMEOUT_CYCLES(4)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .enable                  (enable),
    .core_state              (core_state),
    .decoded_mem_read_enable (rd_en),
    .decoded_mem_write_enable(wr_en),
    .rs                      (rs),
    .rt                      (rt),
    .mem_read_valid          (mem_read_valid),
    .mem_read_address        (mem_read_address),
    .mem_read_ready          (mem_read_ready),
    .mem_read_data           (mem_read_data),
    .mem_write_valid         (mem_write_valid),
    .mem_write_address       (mem_write_address),
    .mem_write_data          (mem_write_data),
    .mem_write_ready         (mem_write_ready),
    .lsu_state               (lsu_state),
    .lsu_out                 (lsu_out),
    .lsu_error               (lsu_error)
  );

  // Advance one active edge and settle; checks and new inputs follow at edge+1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; core_state = 3'b000; rd_en = 1'b0; wr_en = 1'b0;
    rs = 8'h00; rt = 8'h00; mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = 8'h00;
    tick(); tick();
    tests++;
    if ({lsu_state, mem_read_valid, mem_write_valid, lsu_error, lsu_out, mem_read_address, mem_write_data} !== 29'h0) begin
      $display("FAIL reset_state: got st=%b rv=%b wv=%b err=%b out=%h addr=%h wd=%h expected all zero",
               lsu_state, mem_read_valid, mem_write_valid, lsu_error, lsu_out, mem_read_address, mem_write_data);
      fails++;
    end
    reset = 1'b0;
  endtask

  task automatic test_ldr();
    core_state = 3'b011; rd_en = 1'b1; rs = 8'h2A;
    tick();  // edge 0
    tests++;
    if ({lsu_state, mem_read_valid} !== {2'b01, 1'b0}) begin
      $display("FAIL ldr_requesting: got st=%b rv=%b expected st=01 rv=0", lsu_state, mem_read_valid); fails++;
    end
    core_state = 3'b100;
    tick();  // edge 1
    tests++;
    if ({lsu_state, mem_read_valid, mem_write_valid, mem_read_address} !== {2'b10, 1'b1, 1'b0, 8'h2A}) begin
      $display("FAIL ldr_valid: got st=%b rv=%b wv=%b addr=%h expected st=10 rv=1 wv=0 addr=2a",
               lsu_state, mem_read_valid, mem_write_valid, mem_read_address); fails++;
    end
    tick(); tick();  // edges 2,3
    tests++;
    if ({lsu_state, mem_read_valid} !== {2'b10, 1'b1}) begin
      $display("FAIL ldr_hold: got st=%b rv=%b expected st=10 rv=1", lsu_state, mem_read_valid); fails++;
    end
    mem_read_ready = 1'b1; mem_read_data = 8'hC3;
    tick();  // edge 4
    mem_read_ready = 1'b0; mem_read_data = 8'h00;
    tests++;
    if ({lsu_state, mem_read_valid, lsu_out, lsu_error} !== {2'b11, 1'b0, 8'hC3, 1'b0}) begin
      $display("FAIL ldr_done: got st=%b rv=%b out=%h err=%b expected st=11 rv=0 out=c3 err=0",
               lsu_state, mem_read_valid, lsu_out, lsu_error); fails++;
    end
    core_state = 3'b110;
    tick();
    tests++;
    if ({lsu_state, lsu_out} !== {2'b00, 8'hC3}) begin
      $display("FAIL ldr_update_idle: got st=%b out=%h expected st=00 out=c3", lsu_state, lsu_out); fails++;
    end
    rd_en = 1'b0; core_state = 3'b000;
  endtask

  task automatic test_str();
    core_state = 3'b011; wr_en = 1'b1; rs = 8'h10; rt = 8'h55;
    tick();
    core_state = 3'b100;
    tick();
    tests++;
    if ({lsu_state, mem_write_valid, mem_read_valid, mem_write_address, mem_write_data} !== {2'b10, 1'b1, 1'b0, 8'h10, 8'h55}) begin
      $display("FAIL str_valid: got st=%b wv=%b rv=%b addr=%h wd=%h expected st=10 wv=1 rv=0 addr=10 wd=55",
               lsu_state, mem_write_valid, mem_read_valid, mem_write_address, mem_write_data); fails++;
    end
    mem_read_ready = 1'b1;  // wrong channel: ignored
    tick(); tick(); tick();  // three ready-less waiting edges
    mem_read_ready = 1'b0;
    tests++;
    if ({lsu_state, mem_write_valid} !== {2'b10, 1'b1}) begin
      $display("FAIL str_wait: got st=%b wv=%b expected st=10 wv=1", lsu_state, mem_write_valid); fails++;
    end
    mem_write_ready = 1'b1;  // lands on the timeout expiry edge: completion wins
    tick();
    mem_write_ready = 1'b0;
    tests++;
    if ({lsu_state, mem_write_valid, lsu_error, lsu_out} !== {2'b11, 1'b0, 1'b0, 8'hC3}) begin
      $display("FAIL str_done: got st=%b wv=%b err=%b out=%h expected st=11 wv=0 err=0 out=c3",
               lsu_state, mem_write_valid, lsu_error, lsu_out); fails++;
    end
    core_state = 3'b110;
    tick();
    wr_en = 1'b0; core_state = 3'b000;
  endtask

  task automatic test_timeout();
    core_state = 3'b011; rd_en = 1'b1; rs = 8'h33;
    tick();
    core_state = 3'b100;
    tick(); tick(); tick(); tick();  // edges 1..4
    tests++;
    if ({lsu_state, mem_read_valid, lsu_error} !== {2'b10, 1'b1, 1'b0}) begin
      $display("FAIL to_before: got st=%b rv=%b err=%b expected st=10 rv=1 err=0", lsu_state, mem_read_valid, lsu_error); fails++;
    end
    tick();  // edge 5: fourth ready-less waiting edge
    tests++;
    if ({lsu_state, mem_read_valid, lsu_error, lsu_out} !== {2'b11, 1'b0, 1'b1, 8'h00}) begin
      $display("FAIL to_expire: got st=%b rv=%b err=%b out=%h expected st=11 rv=0 err=1 out=00",
               lsu_state, mem_read_valid, lsu_error, lsu_out); fails++;
    end
    core_state = 3'b011;  // stray request code while DONE
    tick();
    tests++;
    if ({lsu_state, mem_read_valid, lsu_error} !== {2'b11, 1'b0, 1'b1}) begin
      $display("FAIL stray_request: got st=%b rv=%b err=%b expected st=11 rv=0 err=1", lsu_state, mem_read_valid, lsu_error); fails++;
    end
    core_state = 3'b110;
    tick();
    core_state = 3'b011;
    tick();
    tests++;
    if ({lsu_state, lsu_error} !== {2'b01, 1'b0}) begin
      $display("FAIL to_err_clear: got st=%b err=%b expected st=01 err=0", lsu_state, lsu_error); fails++;
    end
    core_state = 3'b100;
    mem_read_ready = 1'b1; mem_read_data = 8'h5A;  // ready in REQUESTING is ignored
    tick();
    tests++;
    if ({lsu_state, mem_read_valid} !== {2'b10, 1'b1}) begin
      $display("FAIL early_ready: got st=%b rv=%b expected st=10 rv=1", lsu_state, mem_read_valid); fails++;
    end
    tick();
    mem_read_ready = 1'b0;
    core_state = 3'b110;
    tick();
    rd_en = 1'b0; core_state = 3'b000;
  endtask

  task automatic test_both_enables();
    core_state = 3'b011; rd_en = 1'b1; wr_en = 1'b1; rs = 8'h07; rt = 8'hEE;
    tick();
    core_state = 3'b100;
    tick();
    tests++;
    if ({mem_read_valid, mem_write_valid, mem_read_address} !== {1'b1, 1'b0, 8'h07}) begin
      $display("FAIL both_read_only: got rv=%b wv=%b addr=%h expected rv=1 wv=0 addr=07",
               mem_read_valid, mem_write_valid, mem_read_address); fails++;
    end
    mem_write_ready = 1'b1;
    tick();
    mem_write_ready = 1'b0;
    tests++;
    if ({lsu_state, mem_read_valid, mem_write_valid} !== {2'b10, 1'b1, 1'b0}) begin
      $display("FAIL both_wready_ignored: got st=%b rv=%b wv=%b expected st=10 rv=1 wv=0",
               lsu_state, mem_read_valid, mem_write_valid); fails++;
    end
    mem_read_ready = 1'b1; mem_read_data = 8'h99;
    tick();
    mem_read_ready = 1'b0;
    tests++;
    if ({lsu_state, lsu_out} !== {2'b11, 8'h99}) begin
      $display("FAIL both_done: got st=%b out=%h expected st=11 out=99", lsu_state, lsu_out); fails++;
    end
    core_state = 3'b110;
    tick();
    rd_en = 1'b0; wr_en = 1'b0; core_state = 3'b000;
  endtask

  task automatic test_mid_reset();
    core_state = 3'b011; rd_en = 1'b1; rs = 8'h44;
    tick();
    core_state = 3'b100;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if ({lsu_state, mem_read_valid, mem_write_valid, lsu_out, lsu_error} !== 13'h0) begin
      $display("FAIL mid_reset: got st=%b rv=%b wv=%b out=%h err=%b expected all zero",
               lsu_state, mem_read_valid, mem_write_valid, lsu_out, lsu_error); fails++;
    end
    rd_en = 1'b0; core_state = 3'b000;
  endtask

  task automatic test_disabled();
    enable = 1'b0; core_state = 3'b011; rd_en = 1'b1; rs = 8'h21;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if ({lsu_state, mem_read_valid, mem_write_valid} !== 4'b0000) begin
        $display("FAIL disabled_%0d: got st=%b rv=%b wv=%b expected st=00 rv=0 wv=0",
                 i, lsu_state, mem_read_valid, mem_write_valid); fails++;
      end
    end
    enable = 1'b1; rd_en = 1'b0; core_state = 3'b000;
  endtask

  initial begin
    test_reset();
    test_ldr();
    test_str();
    test_timeout();
    test_both_enables();
    test_mid_reset();
    test_disabled();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
